// File: rtl/t8086_pkg.sv
// Shared t8086 core definitions: address width, reset vector, byte type and
// a constant-foldable ceil(log2) helper for sizing counters.
package t8086_pkg;

  localparam int ADDR_W = 20;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 20'hFFFF0;

  typedef logic [7:0] byte_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pq_byte_buffer.sv
// Shift-compaction byte store: the oldest byte always lives in slot 0, so the
// decode window is a fixed slice with no read pointer.
module pq_byte_buffer
  import t8086_pkg::*;
#(
  parameter int DEPTH    = 6,
  parameter int WIN      = 6,
  parameter int PUSH_MAX = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic [clog2(WIN+1)-1:0]        pop_n,
  input  logic [clog2(PUSH_MAX+1)-1:0]   push_n,
  input  logic [8*PUSH_MAX-1:0]          push_data,
  output logic [8*WIN-1:0]               win,
  output logic [clog2(DEPTH+1)-1:0]      count
);

  localparam int CNT_W = clog2(DEPTH+1);

  byte_t            mem_q [DEPTH];
  byte_t            mem_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  int               rem;

  // The caller guarantees pop_n <= count_q, so rem is never negative.
  always_comb begin
    rem     = int'(count_q) - int'(pop_n);
    count_d = clr ? '0 : CNT_W'(rem + int'(push_n));
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      byte_t slot_nxt;
      always_comb begin
        slot_nxt = '0;
        if (!clr) begin
          if (gi < rem) begin
            for (int j = 0; j < DEPTH; j++) begin
              if (j == gi + int'(pop_n)) slot_nxt = mem_q[j];
            end
          end else begin
            for (int k = 0; k < PUSH_MAX; k++) begin
              if ((gi == rem + k) && (k < int'(push_n))) slot_nxt = push_data[8*k +: 8];
            end
          end
        end
      end
      assign mem_d[gi] = slot_nxt;
    end

    for (gi = 0; gi < WIN; gi++) begin : g_win
      assign win[8*gi +: 8] = (gi < int'(count_q)) ? mem_q[gi] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues ROM fetches while space allows, appends
// returned bytes, and exposes the oldest WIN bytes plus their linear address.
module prefetch_queue
  import t8086_pkg::*;
#(
  parameter int DEPTH       = 6,
  parameter int WIN         = 6,
  parameter int FETCH_BYTES = 1,
  parameter int ADDR_W      = t8086_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = t8086_pkg::RESET_VECTOR
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        rom_en,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [8*FETCH_BYTES-1:0]    rom_data,
  input  logic                        flush,
  input  logic [ADDR_W-1:0]           flush_addr,
  input  logic [clog2(WIN+1)-1:0]     consume,
  output logic [8*WIN-1:0]            q_bytes,
  output logic [clog2(DEPTH+1)-1:0]   q_count,
  output logic [ADDR_W-1:0]           q_addr,
  output logic                        overrun
);

  localparam int CW = clog2(WIN+1);
  localparam int UW = clog2(FETCH_BYTES+1);

  generate
    if (WIN > DEPTH || (FETCH_BYTES != 1 && FETCH_BYTES != 2) || DEPTH < FETCH_BYTES) begin : g_bad_params
      $fatal(1, "prefetch_queue: illegal DEPTH/WIN/FETCH_BYTES combination");
    end
  endgenerate

  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] q_addr_q, q_addr_d;
  logic              inflight_q, inflight_d;
  logic              fits;
  logic              append;
  logic [CW-1:0]     eff;
  logic [CW-1:0]     pop_n;
  logic [UW-1:0]     push_n;

  always_comb begin
    // Space check ignores same-cycle consume so a request never overfills.
    fits     = (int'(q_count) + (inflight_q ? FETCH_BYTES : 0) + FETCH_BYTES) <= DEPTH;
    rom_en   = !rst && !flush && fits;
    rom_addr = rst ? RESET_ADDR : fetch_addr_q;
    eff      = (int'(consume) > int'(q_count)) ? CW'(q_count) : consume;
    overrun  = !rst && !flush && (int'(consume) > int'(q_count));
    append   = inflight_q && !flush;
    pop_n    = flush ? '0 : eff;
    push_n   = append ? UW'(FETCH_BYTES) : '0;

    fetch_addr_d = fetch_addr_q;
    q_addr_d     = q_addr_q;
    inflight_d   = rom_en;
    if (flush) begin
      fetch_addr_d = flush_addr;
      q_addr_d     = flush_addr;
      inflight_d   = 1'b0;
    end else begin
      if (rom_en) fetch_addr_d = fetch_addr_q + ADDR_W'(FETCH_BYTES);
      q_addr_d = q_addr_q + ADDR_W'(eff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q <= RESET_ADDR;
      q_addr_q     <= RESET_ADDR;
      inflight_q   <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      q_addr_q     <= q_addr_d;
      inflight_q   <= inflight_d;
    end
  end

  pq_byte_buffer #(
    .DEPTH    (DEPTH),
    .WIN      (WIN),
    .PUSH_MAX (FETCH_BYTES)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .pop_n     (pop_n),
    .push_n    (push_n),
    .push_data (rom_data),
    .win       (q_bytes),
    .count     (q_count)
  );

  assign q_addr = q_addr_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a byte scoreboard filled on each observed
// fetch and drained as decode consumes, plus fixed-point checks.
module tb_prefetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, flush1, rom_en1, overrun1;
  logic [19:0] flush_addr1, rom_addr1, q_addr1;
  logic [7:0]  rom_data1;
  logic [2:0]  consume1, q_count1;
  logic [47:0] q_bytes1;

  logic        rst2, flush2, rom_en2, overrun2;
  logic [19:0] flush_addr2, rom_addr2, q_addr2, rom_addr2_p1;
  logic [15:0] rom_data2;
  logic [2:0]  consume2, q_count2;
  logic [47:0] q_bytes2;

  prefetch_queue u_dut1 (
    .clk(clk), .rst(rst1), .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .flush(flush1), .flush_addr(flush_addr1), .consume(consume1), .q_bytes(q_bytes1),
    .q_count(q_count1), .q_addr(q_addr1), .overrun(overrun1)
  );

  prefetch_queue #(.FETCH_BYTES(2)) u_dut2 (
    .clk(clk), .rst(rst2), .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .flush(flush2), .flush_addr(flush_addr2), .consume(consume2), .q_bytes(q_bytes2),
    .q_count(q_count2), .q_addr(q_addr2), .overrun(overrun2)
  );

  // ROM returns the low address byte of each location, one cycle late.
  assign rom_addr2_p1 = rom_addr2 + 20'd1;
  always @(posedge clk) begin
    rom_data1 <= rom_addr1[7:0];
    rom_data2 <= {rom_addr2_p1[7:0], rom_addr2[7:0]};
  end

  int          compared = 0;
  int          mismatched = 0;
  logic [7:0]  sb[$];
  logic [19:0] exp_fetch;
  logic [19:0] exp_qaddr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic [19:0] fa, input logic [2:0] cons);
    int n;
    flush1 = fl;
    flush_addr1 = fa;
    consume1 = cons;
    #1;
    if (rst1) begin
      sb.delete();
      exp_fetch = 20'hFFFF0;
      exp_qaddr = 20'hFFFF0;
    end else if (fl) begin
      sb.delete();
      exp_fetch = fa;
      exp_qaddr = fa;
    end else begin
      n = (int'(cons) < int'(q_count1)) ? int'(cons) : int'(q_count1);
      if (n > 0) check("q_addr_at_consume", q_addr1, exp_qaddr);
      for (int i = 0; i < n; i++) begin
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("head_byte", q_bytes1[8*i +: 8], sb.pop_front());
      end
      exp_qaddr = exp_qaddr + 20'(n);
      $display("cycle consume=%0d eff=%0d q_count=%0d q_addr=%05h", cons, n, q_count1, q_addr1);
    end
    if (rom_en1 && !rst1) begin
      check("rom_addr", rom_addr1, exp_fetch);
      $display("fetch rom_addr=%05h", rom_addr1);
      sb.push_back(exp_fetch[7:0]);
      exp_fetch = exp_fetch + 20'd1;
    end
  endtask

  initial begin
    rst1 = 1'b1; flush1 = 1'b0; flush_addr1 = '0; consume1 = '0;
    rst2 = 1'b1; flush2 = 1'b0; flush_addr2 = '0; consume2 = '0;
    tick();
    drive(1'b0, 20'h0, 3'd0);
    check("rst_rom_en", rom_en1, 1'b0);
    check("rst_rom_addr", rom_addr1, 20'hFFFF0);
    tick();
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Fill from reset with no consumption.
    for (int c = 0; c <= 7; c++) begin
      drive(1'b0, 20'h0, 3'd0);
      if (c == 0) begin
        check("reset_q_count", q_count1, 3'd0);
        check("reset_q_addr", q_addr1, 20'hFFFF0);
        check("reset_overrun", overrun1, 1'b0);
        check("reset_q_bytes", q_bytes1, 48'h0);
      end
      check("fill_rom_en", rom_en1, c <= 5);
      if (c == 2) check("fill_count_c2", q_count1, 3'd1);
      if (c == 7) begin
        check("fill_count_c7", q_count1, 3'd6);
        check("fill_bytes", q_bytes1, 48'hF5F4F3F2F1F0);
        check("fill_q_addr", q_addr1, 20'hFFFF0);
      end
      tick();
    end

    // Partial consume from a full queue, then refill.
    drive(1'b0, 20'h0, 3'd3);
    check("full_rom_en", rom_en1, 1'b0);
    check("full_overrun", overrun1, 1'b0);
    tick();
    drive(1'b0, 20'h0, 3'd0);
    check("after3_count", q_count1, 3'd3);
    check("after3_q_addr", q_addr1, 20'hFFFF3);
    check("after3_rom_en", rom_en1, 1'b1);
    check("after3_rom_addr", rom_addr1, 20'hFFFF6);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 20'h0, 3'd0);
      tick();
    end
    drive(1'b0, 20'h0, 3'd0);
    check("refill_count", q_count1, 3'd6);
    check("refill_bytes", q_bytes1, 48'hF8F7F6F5F4F3);
    tick();

    // Reset mid-run, then flush with FFFF3 in flight.
    rst1 = 1'b1;
    drive(1'b0, 20'h0, 3'd0);
    check("midrst_rom_en", rom_en1, 1'b0);
    tick();
    rst1 = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      drive(1'b0, 20'h0, 3'd0);
      if (c == 0) check("midrst_count", q_count1, 3'd0);
      tick();
    end
    drive(1'b1, 20'h00400, 3'd5);
    check("flush_pre_count", q_count1, 3'd3);
    check("flush_rom_en", rom_en1, 1'b0);
    check("flush_overrun", overrun1, 1'b0);
    tick();
    drive(1'b0, 20'h0, 3'd0);
    check("flush_count", q_count1, 3'd0);
    check("flush_q_addr", q_addr1, 20'h00400);
    check("flush_rom_en_next", rom_en1, 1'b1);
    check("flush_rom_addr", rom_addr1, 20'h00400);
    tick();
    drive(1'b0, 20'h0, 3'd0);
    tick();

    // Steady state: one byte in, one byte out per cycle.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 20'h0, 3'd1);
      check("steady_count", q_count1, 3'd1);
      check("steady_overrun", overrun1, 1'b0);
      check("steady_q_addr", q_addr1, 20'h00400 + 20'(k));
      tick();
    end

    // Over-consume with two bytes queued.
    drive(1'b0, 20'h0, 3'd0);
    tick();
    drive(1'b0, 20'h0, 3'd5);
    check("ovr_pre_count", q_count1, 3'd2);
    check("ovr_pulse", overrun1, 1'b1);
    tick();
    drive(1'b0, 20'h0, 3'd0);
    check("ovr_clear", overrun1, 1'b0);
    check("ovr_count", q_count1, 3'd1);
    check("ovr_q_addr", q_addr1, 20'h0040A);
    tick();

    // Two-byte fetch across the top of the address space.
    flush2 = 1'b1;
    flush_addr2 = 20'hFFFFF;
    drive(1'b0, 20'h0, 3'd0);
    check("fb2_flush_rom_en", rom_en2, 1'b0);
    tick();
    flush2 = 1'b0;
    drive(1'b0, 20'h0, 3'd0);
    check("fb2_rom_en", rom_en2, 1'b1);
    check("fb2_rom_addr0", rom_addr2, 20'hFFFFF);
    check("fb2_count0", q_count2, 3'd0);
    tick();
    drive(1'b0, 20'h0, 3'd0);
    check("fb2_rom_addr1", rom_addr2, 20'h00001);
    tick();
    drive(1'b0, 20'h0, 3'd0);
    check("fb2_count", q_count2, 3'd2);
    check("fb2_bytes", q_bytes2[15:0], 16'h00FF);
    check("fb2_q_addr", q_addr2, 20'hFFFFF);
    $display("fb2 q_count=%0d q_bytes[15:0]=%04h", q_count2, q_bytes2[15:0]);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Parametrised instruction prefetch queue for the t8086 core. It replaces the fixed 5-byte instruction shift register with a DEPTH-byte FIFO, a consume-count interface, flush-on-branch and in-flight tracking.
- It sits between the instruction ROM port and the decode/length stage.
- Each cycle it presents the oldest WIN bytes and their linear address. Decode consumes 0..WIN bytes per cycle.

Parameters:
- DEPTH, 6, queue capacity in bytes; at least FETCH_BYTES and at least WIN.
- WIN, 6, width of the decode peek window in bytes.
- FETCH_BYTES, 1, bytes returned per ROM access; legal values are 1 and 2.
- ADDR_W, 20, width of the linear address.
- RESET_ADDR, 20'hFFFF0, fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rom_en  out  1  fetch request this cycle.
- rom_addr  out  ADDR_W  linear address of the first byte requested.
- rom_data  in  8*FETCH_BYTES  data for the request issued in the previous cycle; byte i is in [8i+7:8i].
- flush  in  1  discard the queue and restart fetching at flush_addr.
- flush_addr  in  ADDR_W  restart address, sampled when flush=1.
- consume  in  clog2(WIN+1)  number of bytes decode removes this cycle.
- q_bytes  out  8*WIN  queue head window; byte 0 (oldest) is in [7:0].
- q_count  out  clog2(DEPTH+1)  number of valid bytes in the queue.
- q_addr  out  ADDR_W  linear address of q_bytes byte 0.
- overrun  out  1  one-cycle pulse when consume exceeds q_count.

Behaviour:
- Reset (rst=1 at a clock edge):
  - q_count=0, in-flight flag cleared, fetch_addr=q_addr=RESET_ADDR, overrun=0, storage cleared.
  - rom_en=0 and rom_addr=RESET_ADDR in every cycle where rst=1.
  - Reset asserted mid-fill discards any in-flight data.
- ROM timing: rom_data is valid during cycle N+1 for a request issued in cycle N. It is captured on the edge that ends N+1 and appears on q_bytes/q_count in N+2.
- Issue rule: rom_en = !rst && !flush && (q_count + inflight*FETCH_BYTES + FETCH_BYTES <= DEPTH).
  - The rule is conservative: consume in the same cycle is not credited.
  - rom_addr=fetch_addr.
  - On issue, fetch_addr += FETCH_BYTES, modulo 2^ADDR_W.
  - At most one request is in flight, so steady-state fetch rate is one request per cycle.
- Append: if a request was issued in the previous cycle and no flush/rst occurred since, all FETCH_BYTES bytes are written at the tail in address order.
- Consume:
  - eff = min(consume, q_count).
  - Head advances by eff; q_addr += eff, modulo 2^ADDR_W.
  - overrun=1 for that cycle when consume > q_count.
- Simultaneous consume and append in one edge:
  - next q_count = q_count - eff + appended.
  - Appended bytes land directly after the remaining bytes.
  - The queue never exceeds DEPTH, which the issue rule guarantees.
- Flush (priority below rst, above everything else):
  - Next q_count=0, in-flight data discarded, fetch_addr=q_addr=flush_addr.
  - consume is ignored and overrun=0.
  - rom_en=0 in the flush cycle; the first request to flush_addr issues in the following cycle.
- Window: q_bytes bytes at index >= q_count are driven as 8'h00.
- Wrap-around: fetch_addr and q_addr both wrap 20'hFFFFF -> 20'h00000 with no gap.
  - With FETCH_BYTES=2 at address 20'hFFFFF, byte 1 is address 20'h00000.
- Elaboration: fatal error unless WIN <= DEPTH, FETCH_BYTES is 1 or 2, and DEPTH >= FETCH_BYTES.

Decomposition:
- t8086_pkg holds: ADDR_W=20, RESET_VECTOR=20'hFFFF0, a byte typedef, and a clog2 helper function.
- One sub-module, pq_byte_buffer, holds the DEPTH-byte storage.
  - It presents the head window and has inputs pop_n (0..WIN), push_n (0..FETCH_BYTES) and push_data.
  - It is implemented as a shift-compaction buffer so byte 0 is always at index 0.
- prefetch_queue itself owns fetch_addr, q_addr, the in-flight flag, flush/reset priority and the overrun pulse.

Test Plan:
1. Defaults, rst released at cycle 0, consume=0, ROM returns addr[7:0]:
   - rom_addr runs FFFF0, FFFF1, ... FFFF5, after which rom_en stays 0.
   - q_count reads 1 at cycle 2 and 6 at cycle 7.
   - q_bytes = {F5,F4,F3,F2,F1,F0}; q_addr=FFFF0.
2. Full queue, consume=3 for one cycle:
   - q_count drops to 3 and q_addr=FFFF3.
   - rom_en re-asserts the next cycle at FFFF6.
   - q_count refills back to 6.
3. Steady-state consume=1 every cycle after the first byte arrives:
   - q_count holds at 1 with no stall.
   - q_addr increments by 1 per cycle; overrun is never asserted.
4. flush=1 with flush_addr=20'h00400 while a request to FFFF3 is in flight:
   - The FFFF3 data is discarded and q_count=0 the next cycle.
   - rom_addr=00400 one cycle after flush; q_addr=00400.
5. q_count=2 and consume=5:
   - overrun pulses for one cycle, q_count becomes 0 (plus any append), q_addr advances by 2.
6. FETCH_BYTES=2 with flush to 20'hFFFFF:
   - The first request returns bytes for FFFFF and 00000.
   - q_bytes[15:0] = {00, FF} and q_count=2.
   - The next rom_addr is 00001.
